// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction memory port, execute redirect and the
// valid/ready queue toward decode. The master modport is the fetch controller.
interface imem_fetch_ctrl_if;
    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        input  fetch_en, imem_instr, redirect_valid, redirect_pc, if_ready,
        output imem_pc, if_valid, if_pc, if_instr, fault, fault_pc
    );

    modport slave (
        output fetch_en, imem_instr, redirect_valid, redirect_pc, if_ready,
        input  imem_pc, if_valid, if_pc, if_instr, fault, fault_pc
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, queues {pc, instr} pairs for decode,
// flushes on redirect. Define FETCH_FAULT_CHECK_EN to enable fetch address fault checking.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 64,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    imem_fetch_ctrl_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]       state;
    logic [31:0]      fetch_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [31:0]      q_pc    [FIFO_DEPTH];
    logic [31:0]      q_instr [FIFO_DEPTH];

    logic pop;
    logic room;
    logic push_try;
    logic push;
    logic fault_cond;
    logic redir_legal;

    // Redirect outranks everything: it suppresses both the pop and the push.
    assign pop      = bus.if_valid && bus.if_ready && !bus.redirect_valid;
    assign room     = (count != FULL_CNT) || pop;
    assign push_try = bus.fetch_en && (state != ST_FAULT) && !bus.redirect_valid && room;
    assign push     = push_try && !fault_cond;

`ifdef FETCH_FAULT_CHECK_EN
    function automatic logic pc_legal(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && ((pc >> 2) < 32'(IMEM_DEPTH));
    endfunction

    logic        fault_q;
    logic [31:0] fault_pc_q;

    assign fault_cond  = push_try && !pc_legal(fetch_pc);
    assign redir_legal = pc_legal(bus.redirect_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else if ((state == ST_FAULT) && bus.redirect_valid) begin
            if (redir_legal) fault_q <= 1'b0;
            else             fault_pc_q <= bus.redirect_pc;
        end else if (fault_cond) begin
            fault_q    <= 1'b1;
            fault_pc_q <= fetch_pc;
        end
    end

    assign bus.fault    = fault_q;
    assign bus.fault_pc = fault_pc_q;
`else
    assign fault_cond   = 1'b0;
    assign redir_legal  = 1'b1;
    assign bus.fault    = 1'b0;
    assign bus.fault_pc = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (state == ST_FAULT) begin
            if (bus.redirect_valid && redir_legal)
                state <= bus.fetch_en ? ST_RUN : ST_IDLE;
        end else if (fault_cond) begin
            state <= ST_FAULT;
        end else begin
            state <= bus.fetch_en ? ST_RUN : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                tail     <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage is fully registered; decode never sees imem_instr directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (push) begin
            q_pc[tail]    <= fetch_pc;
            q_instr[tail] <= bus.imem_instr;
        end
    end

    assign bus.imem_pc  = fetch_pc;
    assign bus.if_valid = (count != '0);
    assign bus.if_pc    = q_pc[head];
    assign bus.if_instr = q_instr[head];
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed vector table, hand sequences for reset/fault,
// and randomized traffic checked against a queue-based reference model.
module tb_imem_fetch_ctrl;
    localparam int          DEPTH     = 2;
    localparam int          IMEM_D    = 64;
    localparam logic [31:0] RST_PC    = 32'h0000_0000;
`ifdef FETCH_FAULT_CHECK_EN
    localparam bit          CHK_FAULT = 1'b1;
`else
    localparam bit          CHK_FAULT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(.RESET_PC(RST_PC), .IMEM_DEPTH(IMEM_D), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        case (pc)
            32'h0000_0000: return 32'hFE01_0113;
            32'h0000_0004: return 32'h0081_2E23;
            default:       return (pc * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    assign bus.imem_instr = instr_of(bus.imem_pc);

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: fetch PC, a queue of pending entries, and a fault flag.
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fault_pc;

    function automatic bit legal(input logic [31:0] pc);
        return (pc % 4 == 0) && (pc < 32'(IMEM_D * 4));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc       = RST_PC;
        m_fault    = 1'b0;
        m_fault_pc = '0;
    endtask

    task automatic model_step(input logic fe, input logic rv, input logic [31:0] rpc,
                              input logic rdy);
        bit popped, space;
        if (rv) begin
            mq.delete();
            if (m_fault) begin
                if (legal(rpc)) m_fault = 1'b0;
                else            m_fault_pc = rpc;
            end
            m_pc = rpc;
        end else begin
            popped = (mq.size() != 0) && rdy;
            space  = (mq.size() < DEPTH) || popped;
            if (popped) void'(mq.pop_front());
            if (fe && !m_fault && space) begin
                if (CHK_FAULT && !legal(m_pc)) begin
                    m_fault    = 1'b1;
                    m_fault_pc = m_pc;
                end else begin
                    mq.push_back('{m_pc, instr_of(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, check this cycle's outputs, advance the model.
    task automatic step(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy,
                        input bit use_tbl, input logic ev, input logic [31:0] epc,
                        input logic [31:0] eimem);
        bus.fetch_en       = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.if_ready       = rdy;
        @(negedge clk);
        chk("imem_pc", bus.imem_pc, m_pc);
        chk("if_valid", 32'(bus.if_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("if_pc", bus.if_pc, mq[0].pc);
            chk("if_instr", bus.if_instr, mq[0].instr);
        end
        chk("fault", 32'(bus.fault), 32'(m_fault));
        chk("fault_pc", bus.fault_pc, m_fault_pc);
        if (use_tbl) begin
            chk("tbl_if_valid", 32'(bus.if_valid), 32'(ev));
            chk("tbl_imem_pc", bus.imem_pc, eimem);
            if (ev) begin
                chk("tbl_if_pc", bus.if_pc, epc);
                chk("tbl_if_instr", bus.if_instr, instr_of(epc));
            end
        end
        model_step(fe, rv, rpc, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input logic fe, input logic rv, input logic [31:0] rpc,
                             input logic rdy);
        step(fe, rv, rpc, rdy, 1'b0, 1'b0, '0, '0);
    endtask

    typedef struct {
        logic        fe;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eimem;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Startup, backpressure stall, full-FIFO redirect with pop, fetch_en drop and drain.
        tbl[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h00};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h0,  32'h04};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  32'h08};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  32'h0C};
        tbl[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  32'h0C};
        tbl[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  32'h0C};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h4,  32'h0C};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h4,  32'h0C};
        tbl[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h8,  32'h10};
        tbl[9]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'hC,  32'h14};
        tbl[10] = '{1'b1, 1'b1, 32'h5C, 1'b1, 1'b1, 32'hC,  32'h14};
        tbl[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h5C};
        tbl[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 32'h5C, 32'h60};
        tbl[13] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 32'h60, 32'h64};
        tbl[14] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h60, 32'h68};
        tbl[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 32'h64, 32'h68};
        tbl[16] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  32'h68};

        rst_n              = 1'b0;
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_instr", bus.if_instr, 32'h0);
        chk("rst_imem_pc", bus.imem_pc, RST_PC);
        chk("rst_fault", 32'(bus.fault), 32'h0);
        chk("rst_fault_pc", bus.fault_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++)
            step(tbl[i].fe, tbl[i].rv, tbl[i].rpc, tbl[i].rdy,
                 1'b1, tbl[i].ev, tbl[i].epc, tbl[i].eimem);

        // Address wrap at the top of the 32-bit space.
        idle_step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (6) idle_step(1'b1, 1'b0, '0, 1'b1);

`ifdef FETCH_FAULT_CHECK_EN
        idle_step(1'b1, 1'b1, 32'h0000_00F8, 1'b1);
        idle_step(1'b1, 1'b0, '0, 1'b1);
        idle_step(1'b1, 1'b0, '0, 1'b1);
        chk("flt_last_pc", bus.if_pc, 32'h0000_00FC);
        idle_step(1'b1, 1'b0, '0, 1'b1);
        chk("flt_set", 32'(bus.fault), 32'h1);
        chk("flt_pc", bus.fault_pc, 32'h0000_0100);
        idle_step(1'b1, 1'b1, 32'h0000_0006, 1'b1);
        chk("flt_hold", 32'(bus.fault), 32'h1);
        chk("flt_pc_redir", bus.fault_pc, 32'h0000_0006);
        idle_step(1'b1, 1'b1, 32'h0000_0000, 1'b1);
        chk("flt_clear", 32'(bus.fault), 32'h0);
        idle_step(1'b1, 1'b0, '0, 1'b1);
        chk("flt_resume", bus.if_pc, 32'h0000_0000);
        idle_step(1'b1, 1'b1, 32'h0000_0010, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            logic        fe, rv, rdy;
            logic [31:0] rpc;
            fe  = ($urandom % 8) != 0;
            rdy = ($urandom % 4) != 0;
            rv  = ($urandom % 12) == 0;
            case ($urandom % 8)
                0:       rpc = 32'hFFFF_FFF0;
                1:       rpc = 32'h0000_00F4;
                default: rpc = {$urandom_range(0, 50), 2'b00};
            endcase
            idle_step(fe, rv, rpc, rdy);
        end

        // Asynchronous reset with the queue full and fetch stalled.
        idle_step(1'b1, 1'b1, 32'h0000_0020, 1'b0);
        repeat (4) idle_step(1'b1, 1'b0, '0, 1'b0);
        chk("full_valid", 32'(bus.if_valid), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_if_valid", 32'(bus.if_valid), 32'h0);
        chk("arst_if_pc", bus.if_pc, 32'h0);
        chk("arst_if_instr", bus.if_instr, 32'h0);
        chk("arst_imem_pc", bus.imem_pc, RST_PC);
        chk("arst_fault", 32'(bus.fault), 32'h0);
        @(negedge clk);
        bus.fetch_en = 1'b0;
        rst_n        = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        idle_step(1'b1, 1'b0, '0, 1'b1);
        chk("post_rst_pc", bus.if_pc, RST_PC);
        repeat (4) idle_step(1'b1, 1'b0, '0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
